// File: rtl/glitch_sequencer.sv
// Multi-pulse glitch sequencer on the fast glitch clock.
// Fires up to DEPTH power-dip pulses per trigger edge. Each pulse takes its delay and
// duration from a slot table. The block also provides auto-rearm, abort and a status word.
// Optional feature macro: GLITCH_TIMEOUT_EN. When it is defined, an ARMED-state timeout
// is built, and status bit 5 reports that the timeout fired.
// Ports:
//   i_Clk, i_Rst_L                  clock, async active-low reset
//   i_target_trigger_in             asynchronous trigger from the target
//   o_target_powerdip_out           glitch output, active level OUT_POL
//   i_glitch_ctrl_DV/i_glitch_ctrl  control strobe and bits:
//                                   [0]arm [1]abort [2]fall-edge [3]rearm [7:4]npulse-1
//   i_slot_DV/idx/delay/duration    slot table write
//   o_glitch_status_DV              pulses for one cycle on every state change
//   o_glitch_status                 [2:0]state [3]done [4]cfg_err [5]timeout [11:8]slot
//                                   [31:16]fire_cnt
//   o_busy                          high whenever the state is not IDLE
module glitch_sequencer #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DEPTH       = 4,
    parameter logic        OUT_POL     = 1'b1,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ARM_TIMEOUT = 32'd1 << 24
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_L,
    input  logic                     i_target_trigger_in,
    output logic                     o_target_powerdip_out,
    input  logic                     i_glitch_ctrl_DV,
    input  logic [7:0]               i_glitch_ctrl,
    input  logic                     i_slot_DV,
    input  logic [$clog2(DEPTH)-1:0] i_slot_idx,
    input  logic [CNT_W-1:0]         i_slot_delay,
    input  logic [CNT_W-1:0]         i_slot_duration,
    output logic                     o_glitch_status_DV,
    output logic [31:0]              o_glitch_status,
    output logic                     o_busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned SW    = 5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_DELAY = 3'd2,
        S_PULSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                   state_q, state_n;
    logic [3:0]               slot_q, slot_n;
    logic [CNT_W-1:0]         cnt_q, cnt_n;
    logic [CNT_W-1:0]         dly_q [DEPTH];
    logic [CNT_W-1:0]         dur_q [DEPTH];
    logic [SW-1:0]            npulse_q;
    logic                     edge_sel_q, rearm_q;
    logic                     done_q, cfg_err_q, timeout_q;
    logic [15:0]              fire_cnt_q;
    logic                     pdip_q, status_dv_q, busy_q;

    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     prev_q, prev2_q, edge_q;

    logic                     arm_req, abort_req, arm_take;
    logic                     slot_bad, slot_wr;
    logic [31:0]              idx_ext;
    logic [SW-1:0]            npulse_req;
    logic [SW-1:0]            start;
    logic                     found;
    logic [3:0]               found_idx;
    state_t                   go_state;
    logic [3:0]               go_slot;
    logic [CNT_W-1:0]         go_cnt;
    logic [IDX_W-1:0]         cur;
    logic                     seq_done, tmo_hit;

    assign arm_req    = i_glitch_ctrl_DV & i_glitch_ctrl[0] & ~i_glitch_ctrl[1];
    assign abort_req  = i_glitch_ctrl_DV & i_glitch_ctrl[1];
    assign arm_take   = arm_req & (state_q == S_IDLE);
    assign idx_ext    = 32'(i_slot_idx);
    assign slot_bad   = i_slot_DV & ((state_q != S_IDLE) | (idx_ext >= DEPTH));
    assign slot_wr    = i_slot_DV & ~slot_bad;
    assign npulse_req = SW'(i_glitch_ctrl[7:4]) + SW'(1);
    assign cur        = slot_q[IDX_W-1:0];

    // Trigger synchroniser followed by a registered edge detector on the selected edge
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            prev2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], i_target_trigger_in};
            prev_q  <= sync_q[SYNC_STAGES-1];
            prev2_q <= prev_q;
            edge_q  <= edge_sel_q ? (~prev_q & prev2_q) : (prev_q & ~prev2_q);
        end
    end

`ifdef GLITCH_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(ARM_TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt_q;

    // ARMED-state watchdog; it reloads on every entry into ARMED
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tmo_cnt_q <= '0;
        end else if (state_n == S_ARMED && state_q != S_ARMED) begin
            tmo_cnt_q <= TMO_W'(ARM_TIMEOUT - 1);
        end else if (state_q == S_ARMED && tmo_cnt_q != '0) begin
            tmo_cnt_q <= tmo_cnt_q - TMO_W'(1);
        end
    end
`endif

    // Find the lowest slot at or after 'start' that does anything at all.
    // Slots whose delay and duration are both zero are skipped in zero time.
    always_comb begin
        start     = (state_q == S_ARMED) ? '0 : ({1'b0, slot_q} + SW'(1));
        found     = 1'b0;
        found_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (SW'(i) >= start && SW'(i) < npulse_q &&
                (dly_q[IDX_W'(i)] != '0 || dur_q[IDX_W'(i)] != '0)) begin
                found     = 1'b1;
                found_idx = 4'(i);
            end
        end
    end

    // Entry point of the next slot: its delay phase, or its pulse phase, or DONE
    always_comb begin
        go_state = S_DONE;
        go_slot  = slot_q;
        go_cnt   = cnt_q;
        if (found) begin
            go_slot = found_idx;
            if (dly_q[found_idx[IDX_W-1:0]] != '0) begin
                go_state = S_DELAY;
                go_cnt   = dly_q[found_idx[IDX_W-1:0]];
            end else begin
                go_state = S_PULSE;
                go_cnt   = dur_q[found_idx[IDX_W-1:0]];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_n  = state_q;
        slot_n   = slot_q;
        cnt_n    = cnt_q;
        tmo_hit  = 1'b0;
        seq_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arm_req) state_n = S_ARMED;
            end
            S_ARMED: begin
                if (edge_q) begin
                    state_n = go_state;
                    slot_n  = go_slot;
                    cnt_n   = go_cnt;
                end
`ifdef GLITCH_TIMEOUT_EN
                else if (tmo_cnt_q == '0) begin
                    state_n = S_IDLE;
                    tmo_hit = 1'b1;
                end
`endif
            end
            S_DELAY: begin
                if (cnt_q <= CNT_W'(1)) begin
                    if (dur_q[cur] != '0) begin
                        state_n = S_PULSE;
                        cnt_n   = dur_q[cur];
                    end else begin
                        state_n = go_state;
                        slot_n  = go_slot;
                        cnt_n   = go_cnt;
                    end
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            S_PULSE: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_n = go_state;
                    slot_n  = go_slot;
                    cnt_n   = go_cnt;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_n = rearm_q ? S_ARMED : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (abort_req) begin
            state_n = S_IDLE;
            tmo_hit = 1'b0;
        end
        seq_done = (state_n == S_DONE) && (state_q != S_DONE);
    end

    // State, counters, config latch and registered outputs
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= S_IDLE;
            slot_q      <= '0;
            cnt_q       <= '0;
            npulse_q    <= '0;
            edge_sel_q  <= 1'b0;
            rearm_q     <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            timeout_q   <= 1'b0;
            fire_cnt_q  <= '0;
            pdip_q      <= ~OUT_POL;
            status_dv_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                dly_q[i] <= '0;
                dur_q[i] <= '0;
            end
        end else begin
            state_q     <= state_n;
            slot_q      <= slot_n;
            cnt_q       <= cnt_n;
            pdip_q      <= (state_n == S_PULSE) ? OUT_POL : ~OUT_POL;
            status_dv_q <= (state_n != state_q);
            busy_q      <= (state_n != S_IDLE);
            if (arm_take) begin
                edge_sel_q <= i_glitch_ctrl[2];
                rearm_q    <= i_glitch_ctrl[3];
                npulse_q   <= (npulse_req > SW'(DEPTH)) ? SW'(DEPTH) : npulse_req;
                slot_q     <= '0;
            end
            if (arm_take)      done_q <= 1'b0;
            else if (seq_done) done_q <= 1'b1;
            if (slot_bad)      cfg_err_q <= 1'b1;
            else if (arm_take) cfg_err_q <= 1'b0;
            if (tmo_hit)       timeout_q <= 1'b1;
            else if (arm_take) timeout_q <= 1'b0;
            if (seq_done)      fire_cnt_q <= fire_cnt_q + 16'd1;
            if (slot_wr) begin
                dly_q[i_slot_idx] <= i_slot_delay;
                dur_q[i_slot_idx] <= i_slot_duration;
            end
        end
    end

    assign o_target_powerdip_out = pdip_q;
    assign o_glitch_status_DV    = status_dv_q;
    assign o_busy                = busy_q;
    assign o_glitch_status       = {fire_cnt_q, 4'b0, slot_q, 2'b0,
                                    timeout_q, cfg_err_q, done_q, state_q};

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer: slot timing, multi-slot chains, edge select,
// auto-rearm, abort, config errors and reset behaviour.
module tb_glitch_sequencer;

    logic        i_Clk = 1'b0;
    logic        i_Rst_L = 1'b0;
    logic        i_target_trigger_in = 1'b0;
    logic        o_target_powerdip_out;
    logic        i_glitch_ctrl_DV = 1'b0;
    logic [7:0]  i_glitch_ctrl = 8'h00;
    logic        i_slot_DV = 1'b0;
    logic [1:0]  i_slot_idx = 2'd0;
    logic [31:0] i_slot_delay = 32'd0;
    logic [31:0] i_slot_duration = 32'd0;
    logic        o_glitch_status_DV;
    logic [31:0] o_glitch_status;
    logic        o_busy;

    int n_chk = 0;
    int n_err = 0;
    int first_act, last_act, n_act, n_done;

    glitch_sequencer #(
        .CNT_W(32), .DEPTH(4), .OUT_POL(1'b1), .SYNC_STAGES(2), .ARM_TIMEOUT(64)
    ) dut (
        .i_Clk                 (i_Clk),
        .i_Rst_L               (i_Rst_L),
        .i_target_trigger_in   (i_target_trigger_in),
        .o_target_powerdip_out (o_target_powerdip_out),
        .i_glitch_ctrl_DV      (i_glitch_ctrl_DV),
        .i_glitch_ctrl         (i_glitch_ctrl),
        .i_slot_DV             (i_slot_DV),
        .i_slot_idx            (i_slot_idx),
        .i_slot_delay          (i_slot_delay),
        .i_slot_duration       (i_slot_duration),
        .o_glitch_status_DV    (o_glitch_status_DV),
        .o_glitch_status       (o_glitch_status),
        .o_busy                (o_busy)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [31:0] st();
        return 32'(o_glitch_status[2:0]);
    endfunction

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic ctrl(input logic [7:0] c);
        i_glitch_ctrl_DV = 1'b1;
        i_glitch_ctrl    = c;
        step();
        i_glitch_ctrl_DV = 1'b0;
        i_glitch_ctrl    = 8'h00;
    endtask

    task automatic wr_slot(input logic [1:0] idx, input logic [31:0] d, input logic [31:0] w);
        i_slot_DV       = 1'b1;
        i_slot_idx      = idx;
        i_slot_delay    = d;
        i_slot_duration = w;
        step();
        i_slot_DV       = 1'b0;
    endtask

    // Runs n cycles; cycle 0 is the first clock after the call. The trigger goes high
    // after cycle hi and low after cycle lo (-1 = never). Output and DONE cycles are tallied.
    task automatic run(input int n, input int hi, input int lo);
        first_act = -1; last_act = -1; n_act = 0; n_done = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (o_target_powerdip_out) begin
                if (first_act < 0) first_act = i;
                last_act = i;
                n_act++;
            end
            if (st() == 32'd4) n_done++;
            if (i == hi) i_target_trigger_in = 1'b1;
            if (i == lo) i_target_trigger_in = 1'b0;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_out",    32'(o_target_powerdip_out), 32'd0);
        chk("rst_status", o_glitch_status, 32'd0);
        chk("rst_dv",     32'(o_glitch_status_DV), 32'd0);
        chk("rst_busy",   32'(o_busy), 32'd0);
        i_Rst_L = 1'b1;
        step();

        // 1: single slot, delay 16, duration 7, rising edge
        wr_slot(2'd0, 32'd16, 32'd7);
        ctrl(8'h01);
        chk("t1_armed",  st(), 32'd1);
        chk("t1_arm_dv", 32'(o_glitch_status_DV), 32'd1);
        chk("t1_busy",   32'(o_busy), 32'd1);
        i_target_trigger_in = 1'b1;
        run(40, -1, 5);
        chk("t1_first", 32'(first_act), 32'd20);
        chk("t1_last",  32'(last_act), 32'd26);
        chk("t1_count", 32'(n_act), 32'd7);
        chk("t1_done_n", 32'(n_done), 32'd1);
        chk("t1_state", st(), 32'd0);
        chk("t1_fire",  32'(o_glitch_status[31:16]), 32'd1);
        chk("t1_donebit", 32'(o_glitch_status[3]), 32'd1);

        // 2: three slots, back-to-back pulses, last slot has zero width
        wr_slot(2'd0, 32'd4, 32'd2);
        wr_slot(2'd1, 32'd0, 32'd3);
        wr_slot(2'd2, 32'd5, 32'd0);
        ctrl(8'h21);
        i_target_trigger_in = 1'b1;
        run(30, -1, 5);
        chk("t2_first", 32'(first_act), 32'd8);
        chk("t2_last",  32'(last_act), 32'd12);
        chk("t2_count", 32'(n_act), 32'd5);
        chk("t2_done_n", 32'(n_done), 32'd1);
        chk("t2_fire",  32'(o_glitch_status[31:16]), 32'd2);

        // 3: falling-edge mode; rising edge ignored, second edge mid-DELAY ignored
        wr_slot(2'd0, 32'd20, 32'd3);
        ctrl(8'h05);
        i_target_trigger_in = 1'b1;
        run(15, -1, -1);
        chk("t3_rise_ign", 32'(n_act), 32'd0);
        chk("t3_still_armed", st(), 32'd1);
        i_target_trigger_in = 1'b0;
        run(45, 5, 8);
        chk("t3_first", 32'(first_act), 32'd24);
        chk("t3_count", 32'(n_act), 32'd3);
        chk("t3_done_n", 32'(n_done), 32'd1);
        chk("t3_state", st(), 32'd0);

        // 5: abort during PULSE, then slot write while busy
        wr_slot(2'd0, 32'd3, 32'd10);
        ctrl(8'h01);
        i_target_trigger_in = 1'b1;
        run(9, -1, -1);
        chk("t5_pulsing", 32'(o_target_powerdip_out), 32'd1);
        ctrl(8'h02);
        chk("t5_abort_out",  32'(o_target_powerdip_out), 32'd0);
        chk("t5_abort_st",   st(), 32'd0);
        chk("t5_abort_done", 32'(o_glitch_status[3]), 32'd0);
        chk("t5_abort_dv",   32'(o_glitch_status_DV), 32'd1);
        ctrl(8'h01);
        wr_slot(2'd0, 32'd99, 32'd99);
        chk("t5_cfg_err", 32'(o_glitch_status[4]), 32'd1);
        ctrl(8'h02);
        chk("t5_cfg_sticky", 32'(o_glitch_status[4]), 32'd1);
        i_target_trigger_in = 1'b0;
        repeat (5) step();
        ctrl(8'h01);
        chk("t5_cfg_clr", 32'(o_glitch_status[4]), 32'd0);
        i_target_trigger_in = 1'b1;
        run(25, -1, 5);
        chk("t5_tbl_first", 32'(first_act), 32'd7);
        chk("t5_tbl_count", 32'(n_act), 32'd10);

        // 6: reset mid-DELAY, then async reset mid-PULSE
        ctrl(8'h01);
        i_target_trigger_in = 1'b1;
        run(6, -1, -1);
        chk("t6_in_delay", st(), 32'd2);
        #1 i_Rst_L = 1'b0;
        i_target_trigger_in = 1'b0;
        #1;
        chk("t6_rst_out",    32'(o_target_powerdip_out), 32'd0);
        chk("t6_rst_status", o_glitch_status, 32'd0);
        chk("t6_rst_dv",     32'(o_glitch_status_DV), 32'd0);
        chk("t6_rst_busy",   32'(o_busy), 32'd0);
        step();
        i_Rst_L = 1'b1;
        step();
        wr_slot(2'd0, 32'd3, 32'd10);
        ctrl(8'h01);
        i_target_trigger_in = 1'b1;
        run(10, -1, -1);
        chk("t6_pulse_on", 32'(o_target_powerdip_out), 32'd1);
        #1 i_Rst_L = 1'b0;
        #1;
        chk("t6_async_off", 32'(o_target_powerdip_out), 32'd0);
        i_target_trigger_in = 1'b0;
        step();
        i_Rst_L = 1'b1;
        step();

        // 4: auto-rearm with two triggers 100 cycles apart
        wr_slot(2'd0, 32'd5, 32'd4);
        ctrl(8'h09);
        i_target_trigger_in = 1'b1;
        run(200, 100, 30);
        chk("t4_count",  32'(n_act), 32'd8);
        chk("t4_last",   32'(last_act), 32'd113);
        chk("t4_done_n", 32'(n_done), 32'd2);
        chk("t4_state",  st(), 32'd1);
        chk("t4_fire",   32'(o_glitch_status[31:16]), 32'd2);
        chk("t4_tmo_bit", 32'(o_glitch_status[5]), 32'd0);
        ctrl(8'h02);

`ifdef GLITCH_TIMEOUT_EN
        // ARMED watchdog with ARM_TIMEOUT=64
        ctrl(8'h01);
        repeat (63) step();
        chk("tmo_armed", st(), 32'd1);
        step();
        chk("tmo_idle", st(), 32'd0);
        chk("tmo_bit",  32'(o_glitch_status[5]), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
